// File: rtl/blink_sched.sv
// blink_sched: round-robin owner of a single blink timing engine shared by
// NCH LED channels. Each enabled channel in turn plays a burst of on/off
// blinks using its latched configuration, then hands the engine onward.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | engine parked, waiting for start
//   S_ON   | led[active_ch] driven high for on*PRE cycles
//   S_OFF  | led low for off*PRE cycles, then next blink or handoff
//   S_NEXT | single handoff cycle: pick next channel or return to idle
module blink_sched #(
    parameter int NCH   = 4,
    parameter int PRE   = 16,
    parameter int TBITS = 4,
    parameter int RBITS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NCH-1:0]         en_mask,
    input  logic                   cfg_we,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [TBITS-1:0]       cfg_on,
    input  logic [TBITS-1:0]       cfg_off,
    input  logic [RBITS-1:0]       cfg_reps,
    output logic [NCH-1:0]         led,
    output logic [$clog2(NCH)-1:0] active_ch,
    output logic                   busy,
    output logic                   flg,
    output logic                   done
);
    localparam int CW = $clog2(NCH);
    localparam int PW = $clog2(PRE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_NEXT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [PW-1:0]     pre_cnt;
    logic [TBITS-1:0]  tick_cnt;
    logic [RBITS-1:0]  rep_cnt;
    logic [TBITS-1:0]  w_on;
    logic [TBITS-1:0]  w_off;
    logic [RBITS-1:0]  w_reps;
    logic              stop_pending;

    logic [TBITS-1:0]  cfg_on_r   [NCH];
    logic [TBITS-1:0]  cfg_off_r  [NCH];
    logic [RBITS-1:0]  cfg_reps_r [NCH];

    logic              tick;
    logic              on_last;
    logic              off_last;
    logic              burst_last;
    logic              cfg_hit;
    logic              load_on;
    logic [RBITS-1:0]  rep_inc;
    logic [CW-1:0]     ch_low;
    logic [CW-1:0]     ch_rr;
    logic [CW-1:0]     ch_sel;
    logic [CW-1:0]     ch_nxt;
    logic [CW-1:0]     idx_low;
    logic [CW-1:0]     idx_rr;
    logic [NCH-1:0]    led_nxt;
    logic              busy_nxt;
    logic              flg_nxt;
    logic              done_nxt;

    // The tick counter compares against duration-1 so a phase lasts exactly
    // duration ticks; working copies are never zero, so no underflow.
    assign tick       = (pre_cnt == PW'(PRE - 1));
    assign on_last    = tick && (tick_cnt == w_on - TBITS'(1));
    assign off_last   = tick && (tick_cnt == w_off - TBITS'(1));
    assign rep_inc    = rep_cnt + RBITS'(1);
    assign burst_last = (rep_inc == w_reps);
    assign cfg_hit    = cfg_we && (int'(cfg_ch) < NCH);

    // Lowest enabled channel, used when leaving idle.
    always_comb begin
        ch_low  = '0;
        idx_low = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx_low = CW'(i);
            if (en_mask[idx_low]) ch_low = idx_low;
        end
    end

    // Next enabled channel strictly after the current one, wrapping back to
    // the current channel itself when it is the only one enabled.
    always_comb begin
        ch_rr  = active_ch;
        idx_rr = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx_rr = CW'((int'(active_ch) + i) % NCH);
            if (en_mask[idx_rr]) ch_rr = idx_rr;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !stop && (en_mask != '0)) state_nxt = S_ON;
            S_ON:   if (on_last) state_nxt = S_OFF;
            S_OFF:  if (off_last) state_nxt = burst_last ? S_NEXT : S_ON;
            S_NEXT: state_nxt = (stop_pending || (en_mask == '0)) ? S_IDLE : S_ON;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next output values; every output is registered from these.
    always_comb begin
        load_on  = ((state == S_IDLE) || (state == S_NEXT)) && (state_nxt == S_ON);
        ch_sel   = (state == S_IDLE) ? ch_low : ch_rr;
        ch_nxt   = load_on ? ch_sel : active_ch;
        led_nxt  = (state_nxt == S_ON) ? (NCH'(1) << ch_nxt) : '0;
        busy_nxt = (state_nxt != S_IDLE);
        flg_nxt  = (state_nxt == S_NEXT);
        done_nxt = (state == S_NEXT) && (state_nxt == S_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= '0;
            active_ch <= '0;
            busy      <= 1'b0;
            flg       <= 1'b0;
            done      <= 1'b0;
        end else begin
            led       <= led_nxt;
            active_ch <= ch_nxt;
            busy      <= busy_nxt;
            flg       <= flg_nxt;
            done      <= done_nxt;
        end
    end

    // Timing engine, burst bookkeeping, stop request and channel configs.
    // A config write landing on the same edge as a burst start is not seen
    // by that burst: the working copy takes the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt      <= '0;
            tick_cnt     <= '0;
            rep_cnt      <= '0;
            w_on         <= TBITS'(1);
            w_off        <= TBITS'(1);
            w_reps       <= RBITS'(1);
            stop_pending <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cfg_on_r[i]   <= TBITS'(1);
                cfg_off_r[i]  <= TBITS'(1);
                cfg_reps_r[i] <= RBITS'(1);
            end
        end else begin
            if (cfg_hit) begin
                cfg_on_r[cfg_ch]   <= cfg_on;
                cfg_off_r[cfg_ch]  <= cfg_off;
                cfg_reps_r[cfg_ch] <= cfg_reps;
            end

            if (done_nxt)
                stop_pending <= 1'b0;
            else if (stop && (state != S_IDLE))
                stop_pending <= 1'b1;

            if ((state_nxt != state) || (state == S_IDLE) || (state == S_NEXT)) begin
                pre_cnt  <= '0;
                tick_cnt <= '0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                if (tick) tick_cnt <= tick_cnt + TBITS'(1);
            end

            if (load_on) begin
                w_on    <= (cfg_on_r[ch_sel]   == '0) ? TBITS'(1) : cfg_on_r[ch_sel];
                w_off   <= (cfg_off_r[ch_sel]  == '0) ? TBITS'(1) : cfg_off_r[ch_sel];
                w_reps  <= (cfg_reps_r[ch_sel] == '0) ? RBITS'(1) : cfg_reps_r[ch_sel];
                rep_cnt <= '0;
            end else if ((state == S_OFF) && (state_nxt == S_ON)) begin
                rep_cnt <= rep_inc;
            end
        end
    end

endmodule

// File: tb/tb_blink_sched.sv
// tb_blink_sched: directed stimulus for blink_sched with a cycle-level
// reference model (remaining-cycle countdown per phase) compared every cycle,
// plus literal per-cycle expectations for the hand-worked scenarios.
module tb_blink_sched;
    localparam int NCH   = 4;
    localparam int PRE   = 4;
    localparam int TBITS = 4;
    localparam int RBITS = 3;

    localparam int MI  = 0;
    localparam int MON = 1;
    localparam int MOF = 2;
    localparam int MNX = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [NCH-1:0]   en_mask;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [TBITS-1:0] cfg_on;
    logic [TBITS-1:0] cfg_off;
    logic [RBITS-1:0] cfg_reps;
    logic [NCH-1:0]   led;
    logic [1:0]       active_ch;
    logic             busy;
    logic             flg;
    logic             done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    blink_sched #(.NCH(NCH), .PRE(PRE), .TBITS(TBITS), .RBITS(RBITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .en_mask   (en_mask),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_on    (cfg_on),
        .cfg_off   (cfg_off),
        .cfg_reps  (cfg_reps),
        .led       (led),
        .active_ch (active_ch),
        .busy      (busy),
        .flg       (flg),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_mode = MI;
    int  m_rem  = 0;
    int  m_left = 0;
    int  m_ch   = 0;
    int  m_on   = 1;
    int  m_off  = 1;
    bit  m_stop = 1'b0;
    int  mc_on   [NCH];
    int  mc_off  [NCH];
    int  mc_reps [NCH];
    int  m_old;
    bit  m_olds;
    int  m_pick;
    bit  m_found;

    logic [NCH-1:0] e_led  = '0;
    logic           e_busy = 1'b0;
    logic           e_flg  = 1'b0;
    logic           e_done = 1'b0;
    logic [1:0]     e_ch   = '0;

    function automatic int nz(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic void m_enter(input int c);
        m_ch   = c;
        m_on   = nz(mc_on[c]);
        m_off  = nz(mc_off[c]);
        m_left = nz(mc_reps[c]);
        m_rem  = m_on * PRE;
        m_mode = MON;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = MI;
            m_ch   = 0;
            m_stop = 1'b0;
            e_done = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                mc_on[i]   = 1;
                mc_off[i]  = 1;
                mc_reps[i] = 1;
            end
        end else begin
            m_old  = m_mode;
            m_olds = m_stop;
            e_done = 1'b0;
            if (m_old != MI && stop) m_stop = 1'b1;
            case (m_old)
                MI: begin
                    if (start && !stop && en_mask != 0) begin
                        m_found = 1'b0;
                        m_pick  = 0;
                        for (int i = 0; i < NCH; i++)
                            if (!m_found && en_mask[i]) begin m_pick = i; m_found = 1'b1; end
                        m_enter(m_pick);
                    end
                end
                MON: begin
                    m_rem--;
                    if (m_rem == 0) begin m_mode = MOF; m_rem = m_off * PRE; end
                end
                MOF: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_left--;
                        if (m_left == 0) m_mode = MNX;
                        else begin m_mode = MON; m_rem = m_on * PRE; end
                    end
                end
                default: begin
                    if (m_olds || en_mask == 0) begin
                        m_mode = MI;
                        m_stop = 1'b0;
                        e_done = 1'b1;
                    end else begin
                        m_found = 1'b0;
                        m_pick  = m_ch;
                        for (int i = 1; i <= NCH; i++)
                            if (!m_found && en_mask[(m_ch + i) % NCH]) begin
                                m_pick = (m_ch + i) % NCH; m_found = 1'b1;
                            end
                        m_enter(m_pick);
                    end
                end
            endcase
            if (cfg_we && int'(cfg_ch) < NCH) begin
                mc_on[cfg_ch]   = int'(cfg_on);
                mc_off[cfg_ch]  = int'(cfg_off);
                mc_reps[cfg_ch] = int'(cfg_reps);
            end
        end
        e_led  = (m_mode == MON) ? (NCH'(1) << m_ch) : '0;
        e_busy = (m_mode != MI);
        e_flg  = (m_mode == MNX);
        e_ch   = 2'(m_ch);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_led",    32'(led),       32'(e_led));
            chk("cmp_active", 32'(active_ch), 32'(e_ch));
            chk("cmp_busy",   32'(busy),      32'(e_busy));
            chk("cmp_flg",    32'(flg),       32'(e_flg));
            chk("cmp_done",   32'(done),      32'(e_done));
            chk("led_onehot", 32'($countones(led) <= 1), 32'h1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input int on, input int off, input int reps);
        nc();
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_on = TBITS'(on); cfg_off = TBITS'(off); cfg_reps = RBITS'(reps);
        nc();
        cfg_we = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            smp();
            if (done === 1'b1) break;
        end
        chk(name, 32'(done), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [NCH-1:0] xl;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; en_mask = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_on = '0; cfg_off = '0; cfg_reps = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        smp();
        chk_en = 1'b1;
        chk("rst_led",    32'(led),       32'h0);
        chk("rst_busy",   32'(busy),      32'h0);
        chk("rst_active", 32'(active_ch), 32'h0);
        chk("rst_flg",    32'(flg),       32'h0);
        chk("rst_done",   32'(done),      32'h0);

        // start with nothing enabled stays idle
        nc(); en_mask = 4'b0000; start = 1'b1;
        nc(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("en0_busy", 32'(busy), 32'h0);
        end

        // start and stop together: stop wins, no done
        nc(); en_mask = 4'b0001; start = 1'b1; stop = 1'b1;
        nc(); start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("ss_busy", 32'(busy), 32'h0);
            chk("ss_done", 32'(done), 32'h0);
        end

        // ch0 on=2 off=1 reps=2, single channel
        cfg_write(0, 2, 1, 2);
        nc(); en_mask = 4'b0001; start = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            nc();
            if (k == 1)  start = 1'b0;
            if (k == 27) stop  = 1'b1;
            if (k == 28) stop  = 1'b0;
            smp();
            if (k <= 26) begin
                xl = ((k >= 1 && k <= 8) || (k >= 13 && k <= 20) || k == 26) ? 4'b0001 : 4'b0000;
                chk("t1_led",  32'(led),  32'(xl));
                chk("t1_flg",  32'(flg),  (k == 25) ? 32'h1 : 32'h0);
                chk("t1_busy", 32'(busy), 32'h1);
            end
        end
        wait_done(60, "t1_done");
        chk("t1_end_led",  32'(led),  32'h0);
        chk("t1_end_busy", 32'(busy), 32'h0);

        // defaults on ch1/ch3, rotation and stop during ch1 ON
        nc(); en_mask = 4'b1010; start = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            nc();
            if (k == 1)  start = 1'b0;
            if (k == 20) stop  = 1'b1;
            if (k == 21) stop  = 1'b0;
            smp();
            if ((k >= 1 && k <= 4) || (k >= 19 && k <= 22)) xl = 4'b0010;
            else if (k >= 10 && k <= 13)                    xl = 4'b1000;
            else                                            xl = 4'b0000;
            chk("t2_led",  32'(led),  32'(xl));
            chk("t2_flg",  32'(flg),  (k == 9 || k == 18 || k == 27) ? 32'h1 : 32'h0);
            chk("t2_done", 32'(done), (k == 28) ? 32'h1 : 32'h0);
            chk("t2_busy", 32'(busy), (k <= 27) ? 32'h1 : 32'h0);
            if (k == 10) chk("t2_ch3", 32'(active_ch), 32'h3);
        end

        // restart at ch1, ignored start while busy, reset in the OFF phase
        nc(); start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            nc();
            if (k == 1) start = 1'b0;
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            if (k == 6) rst   = 1'b1;
            if (k == 7) rst   = 1'b0;
            smp();
            if (k == 1) begin
                chk("t3_ch",  32'(active_ch), 32'h1);
                chk("t3_led", 32'(led),       32'h2);
            end
            if (k == 5) chk("t3_off_led", 32'(led), 32'h0);
            if (k == 7) begin
                chk("t3_rst_led",    32'(led),       32'h0);
                chk("t3_rst_busy",   32'(busy),      32'h0);
                chk("t3_rst_active", 32'(active_ch), 32'h0);
            end
        end

        // ch0 back at defaults; rewrite during the burst and on the entry edge
        nc(); en_mask = 4'b0001; start = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            nc();
            if (k == 1) start = 1'b0;
            if (k == 2)  begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_on = 4'd3; cfg_off = 4'd1; cfg_reps = 3'd1; end
            if (k == 3)  cfg_we = 1'b0;
            if (k == 26) begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_on = 4'd1; cfg_off = 4'd1; cfg_reps = 3'd1; end
            if (k == 27) cfg_we = 1'b0;
            smp();
            xl = ((k >= 1 && k <= 4) || (k >= 10 && k <= 21) || (k >= 27 && k <= 38)) ? 4'b0001 : 4'b0000;
            chk("t4_led", 32'(led), 32'(xl));
            chk("t4_flg", 32'(flg), (k == 9 || k == 26) ? 32'h1 : 32'h0);
        end
        nc(); stop = 1'b1;
        nc(); stop = 1'b0;
        wait_done(40, "t4_done");

        // stop while idle is ignored
        nc(); stop = 1'b1;
        nc(); stop = 1'b0;
        smp();
        chk("idle_stop_busy", 32'(busy), 32'h0);
        chk("idle_stop_done", 32'(done), 32'h0);
        repeat (2) smp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
